led_matrix_renderer: RTL and testbench

- Parametrised successor to the fixed 8x8 maze/banner colour logic. It feeds the WS2812 driver with a registered 24-bit GRB colour for each requested pixel index.
- Holds a multi-page frame buffer of palette indices, written by game logic, plus a writable palette.
- Adds global brightness shift and timed automatic page rotation (banner carousel) on top of the single-frame behaviour.
- Sits between game FSMs (maze, win/fail banners) and ws2812_driver.

---
 rtl/ledmx_pkg.sv | 44 ++++
 rtl/led_matrix_renderer_page_rotator.sv | 107 ++++++++++
 rtl/led_matrix_renderer.sv | 122 ++++++++++++
 tb/tb_led_matrix_renderer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ledmx_pkg.sv
// ledmx_pkg: shared definitions for the LED matrix renderer.
//   - GRB colour constants (G in [23:16], R in [15:8], B in [7:0])
//   - brightness shift encoding and page-control state encoding
//   - clog2 helper for derived widths, dim_grb helper for the output path
package ledmx_pkg;

    localparam logic [23:0] GRB_OFF   = 24'h000000;
    localparam logic [23:0] GRB_GREEN = 24'hFF0000;
    localparam logic [23:0] GRB_RED   = 24'h00FF00;
    localparam logic [23:0] GRB_BLUE  = 24'h0000FF;
    localparam logic [23:0] GRB_WHITE = 24'hFFFFFF;

    // Right-shift applied to every channel.
    typedef enum logic [1:0] {
        BRIGHT_FULL    = 2'd0,
        BRIGHT_HALF    = 2'd1,
        BRIGHT_QUARTER = 2'd2,
        BRIGHT_EIGHTH  = 2'd3
    } bright_e;

    typedef enum logic {
        PG_MANUAL = 1'b0,
        PG_ROTATE = 1'b1
    } page_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 32'sd1;
        r = 32'sd0;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Shift each 8-bit channel independently so no bits leak between channels.
    function automatic logic [23:0] dim_grb(input logic [23:0] c, input logic [1:0] sh);
        return {c[23:16] >> sh, c[15:8] >> sh, c[7:0] >> sh};
    endfunction

endpackage

// File: rtl/led_matrix_renderer_page_rotator.sv
// page_rotator: selects the displayed frame-buffer page.
//   MANUAL : cur_page follows min(page_sel, last_page, NUM_PAGES-1), counter held 0.
//   ROTATE : page advances every DWELL_CYCLES clocks, wrapping to 0 after last_page.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_auto_rot       1 = timed rotation, 0 = manual page
//   i_last_page      highest page in the rotation
//   i_page_sel       manual page request
//   o_cur_page       displayed page (registered)
//   o_page_wrap      one-cycle pulse when rotation wraps to page 0 (registered)
module page_rotator
    import ledmx_pkg::*;
#(
    parameter int NUM_PAGES    = 4,
    parameter int DWELL_CYCLES = 30000000,
    parameter int PAGE_W       = 2
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_auto_rot,
    input  logic [PAGE_W-1:0] i_last_page,
    input  logic [PAGE_W-1:0] i_page_sel,
    output logic [PAGE_W-1:0] o_cur_page,
    output logic              o_page_wrap
);

    localparam int CNT_W = (clog2(DWELL_CYCLES) > 1) ? clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(NUM_PAGES - 1);

    page_state_e       r_state;
    page_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PAGE_W-1:0] r_page;
    logic [PAGE_W-1:0] w_page_nxt;
    logic              r_wrap;
    logic              w_wrap_nxt;
    logic [PAGE_W-1:0] w_lim;
    logic [PAGE_W-1:0] w_manual_page;

    assign w_lim         = (i_last_page < PAGE_MAX) ? i_last_page : PAGE_MAX;
    assign w_manual_page = (i_page_sel < w_lim) ? i_page_sel : w_lim;

    // Next-state and next-output logic for the page controller.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_page_nxt  = r_page;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            PG_MANUAL: begin
                if (i_auto_rot) begin
                    // Arming edge: keep the current page, dwell starts from 0.
                    w_state_nxt = PG_ROTATE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_page_nxt  = w_manual_page;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            PG_ROTATE: begin
                if (!i_auto_rot) begin
                    w_state_nxt = PG_MANUAL;
                    w_page_nxt  = w_manual_page;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    // Also wraps if last_page was lowered below the current page,
                    // and never steps past the last physical page.
                    if ((r_page >= i_last_page) || (r_page >= PAGE_MAX)) begin
                        w_page_nxt = {PAGE_W{1'b0}};
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_page_nxt = r_page + PAGE_W'(1'b1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt = PG_MANUAL;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_page_nxt  = {PAGE_W{1'b0}};
            end
        endcase
    end

    // State, dwell counter, page and wrap-pulse registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= PG_MANUAL;
            r_cnt   <= {CNT_W{1'b0}};
            r_page  <= {PAGE_W{1'b0}};
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_page  <= w_page_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign o_cur_page  = r_page;
    assign o_page_wrap = r_wrap;

endmodule

// File: rtl/led_matrix_renderer.sv
// led_matrix_renderer: multi-page palette frame buffer feeding the WS2812 driver.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_fb_we/page/addr/data       frame-buffer write (addr = y*COLS+x)
//   i_pal_we/sel/color           palette write (entry 0 is fixed OFF)
//   i_bright                     per-channel right shift on output
//   i_auto_rot/last_page/page_sel page control (see page_rotator)
//   i_pixel                      pixel index requested by the driver
//   o_color                      GRB colour of i_pixel, one clock later
//   o_cur_page, o_page_wrap      displayed page, rotation wrap pulse
module led_matrix_renderer
    import ledmx_pkg::*;
#(
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int NUM_PAGES    = 4,
    parameter int PAL_W        = 2,
    parameter int DWELL_CYCLES = 30000000,
    localparam int NPIX   = COLS * ROWS,
    localparam int IDX_W  = clog2(NPIX),
    localparam int PAGE_W = (clog2(NUM_PAGES) > 1) ? clog2(NUM_PAGES) : 1
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fb_we,
    input  logic [PAGE_W-1:0] i_fb_page,
    input  logic [IDX_W-1:0]  i_fb_addr,
    input  logic [PAL_W-1:0]  i_fb_data,
    input  logic              i_pal_we,
    input  logic [PAL_W-1:0]  i_pal_sel,
    input  logic [23:0]       i_pal_color,
    input  logic [1:0]        i_bright,
    input  logic              i_auto_rot,
    input  logic [PAGE_W-1:0] i_last_page,
    input  logic [PAGE_W-1:0] i_page_sel,
    input  logic [IDX_W-1:0]  i_pixel,
    output logic [23:0]       o_color,
    output logic [PAGE_W-1:0] o_cur_page,
    output logic              o_page_wrap
);

    localparam int NPAL = 2 ** PAL_W;

    logic [PAL_W-1:0]  r_mem [NUM_PAGES][NPIX];
    logic [23:0]       r_pal [NPAL];
    logic [23:0]       r_color;
    logic [PAGE_W-1:0] w_cur_page;
    logic              w_fb_ok;
    logic              w_pal_ok;
    logic              w_pix_ok;
    logic [PAL_W-1:0]  w_idx;
    logic [23:0]       w_color;

    page_rotator #(
        .NUM_PAGES    (NUM_PAGES),
        .DWELL_CYCLES (DWELL_CYCLES),
        .PAGE_W       (PAGE_W)
    ) u_page_rotator (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_auto_rot  (i_auto_rot),
        .i_last_page (i_last_page),
        .i_page_sel  (i_page_sel),
        .o_cur_page  (w_cur_page),
        .o_page_wrap (o_page_wrap)
    );

    // Out-of-range writes are dropped rather than aliased onto valid entries.
    assign w_fb_ok  = i_fb_we && (int'(i_fb_page) < NUM_PAGES) && (int'(i_fb_addr) < NPIX);
    assign w_pal_ok = i_pal_we && (i_pal_sel != {PAL_W{1'b0}});
    assign w_pix_ok = (int'(i_pixel) < NPIX);

    // Frame-buffer storage; a same-cycle read sees the pre-write contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int p = 0; p < NUM_PAGES; p++) begin
                for (int a = 0; a < NPIX; a++) begin
                    r_mem[p][a] <= {PAL_W{1'b0}};
                end
            end
        end else if (w_fb_ok) begin
            r_mem[i_fb_page][i_fb_addr] <= i_fb_data;
        end
    end

    // Palette storage; entry 0 is never written so it stays OFF.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int e = 0; e < NPAL; e++) begin
                r_pal[e] <= GRB_OFF;
            end
        end else if (w_pal_ok) begin
            r_pal[i_pal_sel] <= i_pal_color;
        end
    end

    // Pixel lookup through the palette and brightness shift.
    always_comb begin
        w_idx   = {PAL_W{1'b0}};
        w_color = GRB_OFF;
        if (w_pix_ok) begin
            w_idx   = r_mem[w_cur_page][i_pixel];
            w_color = dim_grb(r_pal[w_idx], i_bright);
        end else begin
            w_idx   = {PAL_W{1'b0}};
            w_color = GRB_OFF;
        end
    end

    // Output colour register (one clock read latency).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_color <= GRB_OFF;
        end else begin
            r_color <= w_color;
        end
    end

    assign o_color    = r_color;
    assign o_cur_page = w_cur_page;

endmodule

// File: tb/tb_led_matrix_renderer.sv
// Self-checking bench for led_matrix_renderer (DWELL_CYCLES overridden to 4).
// A behavioural model predicts colour, page and wrap pulse after every clock.
module tb_led_matrix_renderer;

    localparam int DWELL = 4;

    logic        clk;
    logic        rst;
    logic        fb_we;
    logic [1:0]  fb_page;
    logic [5:0]  fb_addr;
    logic [1:0]  fb_data;
    logic        pal_we;
    logic [1:0]  pal_sel;
    logic [23:0] pal_color;
    logic [1:0]  bright;
    logic        auto_rot;
    logic [1:0]  last_page;
    logic [1:0]  page_sel;
    logic [5:0]  pixel;
    logic [23:0] color;
    logic [1:0]  cur_page;
    logic        page_wrap;

    led_matrix_renderer #(.DWELL_CYCLES(DWELL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_fb_we     (fb_we),
        .i_fb_page   (fb_page),
        .i_fb_addr   (fb_addr),
        .i_fb_data   (fb_data),
        .i_pal_we    (pal_we),
        .i_pal_sel   (pal_sel),
        .i_pal_color (pal_color),
        .i_bright    (bright),
        .i_auto_rot  (auto_rot),
        .i_last_page (last_page),
        .i_page_sel  (page_sel),
        .i_pixel     (pixel),
        .o_color     (color),
        .o_cur_page  (cur_page),
        .o_page_wrap (page_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int          m_mem [4][64];
    logic [23:0] m_pal [4];
    int          m_page;
    int          m_dwell;
    bit          m_rot;
    logic [23:0] exp_color;
    int          exp_wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] m_dim(input logic [23:0] c, input int b);
        int d;
        int g;
        int r;
        int bl;
        d  = 1 << b;
        g  = int'(c[23:16]) / d;
        r  = int'(c[15:8]) / d;
        bl = int'(c[7:0]) / d;
        return 24'(g * 65536 + r * 256 + bl);
    endfunction

    task automatic model_reset();
        foreach (m_mem[p, a]) m_mem[p][a] = 0;
        foreach (m_pal[e]) m_pal[e] = 24'h0;
        m_page = 0; m_dwell = 0; m_rot = 0;
        exp_color = 24'h0; exp_wrap = 0;
    endtask

    // Effect of one rising edge, using the inputs the DUT just sampled.
    task automatic model_edge();
        int lim;
        if (rst) begin
            model_reset();
        end else begin
            exp_color = m_dim(m_pal[m_mem[m_page][pixel]], int'(bright));
            exp_wrap  = 0;
            if (!auto_rot) begin
                lim = int'(page_sel);
                if (int'(last_page) < lim) lim = int'(last_page);
                m_page = lim; m_dwell = 0; m_rot = 0;
            end else if (!m_rot) begin
                m_rot = 1; m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == DWELL) begin
                    m_dwell = 0;
                    if (m_page >= int'(last_page)) begin
                        m_page = 0; exp_wrap = 1;
                    end else begin
                        m_page++;
                    end
                end
            end
            if (fb_we) m_mem[fb_page][fb_addr] = int'(fb_data);
            if (pal_we && pal_sel != 2'd0) m_pal[pal_sel] = pal_color;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("color", color, exp_color);
        check_eq("cur_page", cur_page, m_page);
        check_eq("page_wrap", page_wrap, exp_wrap);
    endtask

    // Raise rst between edges and check outputs clear without a clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_color", color, 24'h0);
        check_eq("arst_page", cur_page, 0);
        check_eq("arst_wrap", page_wrap, 0);
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hist [16];
        int wraps;
        rst = 1'b1; fb_we = 1'b0; fb_page = 2'd0; fb_addr = 6'd0; fb_data = 2'd0;
        pal_we = 1'b0; pal_sel = 2'd0; pal_color = 24'h0; bright = 2'd0;
        auto_rot = 1'b0; last_page = 2'd3; page_sel = 2'd0; pixel = 6'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_color", color, 24'h0);
        check_eq("rst_page", cur_page, 0);
        check_eq("rst_wrap", page_wrap, 0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            pixel = 6'(i); bright = 2'($urandom_range(0, 3)); tick();
        end

        // palette + single pixel, brightness shifts
        pal_we = 1'b1; pal_sel = 2'd1; pal_color = 24'hFF0000;
        fb_we = 1'b1; fb_page = 2'd0; fb_addr = 6'd9; fb_data = 2'd1; bright = 2'd0;
        tick();
        pal_sel = 2'd2; pal_color = 24'h00FF00; fb_we = 1'b0; tick();
        pal_we = 1'b0; pixel = 6'd9; tick();
        check_eq("dim0", color, 24'hFF0000);
        bright = 2'd1; tick(); check_eq("dim1", color, 24'h7F0000);
        bright = 2'd3; tick(); check_eq("dim3", color, 24'h1F0000);
        bright = 2'd0;

        // frame-buffer read/write collision
        pixel = 6'd5; fb_we = 1'b1; fb_addr = 6'd5; fb_data = 2'd2; tick();
        check_eq("fb_coll_old", color, 24'h000000);
        fb_we = 1'b0; tick();
        check_eq("fb_coll_new", color, 24'h00FF00);
        // palette collision
        pal_we = 1'b1; pal_sel = 2'd2; pal_color = 24'h0000FF; tick();
        check_eq("pal_coll_old", color, 24'h00FF00);
        pal_we = 1'b0; tick();
        check_eq("pal_coll_new", color, 24'h0000FF);
        // entry 0 cannot be written
        pal_we = 1'b1; pal_sel = 2'd0; pal_color = 24'hFFFFFF; pixel = 6'd0; tick();
        pal_we = 1'b0; tick();
        check_eq("pal0_off", color, 24'h0);

        // rotation 0,1,2,0 with last_page=2
        last_page = 2'd2; page_sel = 2'd0; auto_rot = 1'b1; wraps = 0;
        for (int k = 0; k < 13; k++) begin
            tick(); hist[k] = int'(cur_page); wraps += int'(page_wrap);
        end
        check_eq("rot_hold", hist[3], 0);
        check_eq("rot_p1", hist[4], 1);
        check_eq("rot_p2", hist[8], 2);
        check_eq("rot_p0", hist[12], 0);
        check_eq("rot_wraps", wraps, 1);

        // lower last_page while on page 2
        for (int k = 0; k < 20 && cur_page != 2'd2; k++) tick();
        check_eq("reach_p2", cur_page, 2);
        last_page = 2'd1;
        for (int k = 0; k < 8 && cur_page == 2'd2; k++) tick();
        check_eq("lower_page", cur_page, 0);
        check_eq("lower_wrap", page_wrap, 1);
        auto_rot = 1'b0; page_sel = 2'd3; tick();
        check_eq("manual_clamp", cur_page, 1);

        // reset mid-dwell on page 1, with a write lost in the reset cycle
        last_page = 2'd2; auto_rot = 1'b1; pixel = 6'd9;
        for (int k = 0; k < 20 && cur_page != 2'd1; k++) tick();
        check_eq("reach_p1", cur_page, 1);
        tick();
        fb_we = 1'b1; fb_page = 2'd0; fb_addr = 6'd9; fb_data = 2'd3;
        async_reset();
        fb_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); hist[k] = int'(cur_page);
        end
        check_eq("rst_dwell_hold", hist[3], 0);
        check_eq("rst_dwell_adv", hist[4], 1);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            fb_we     = 1'($urandom_range(0, 1));
            fb_page   = 2'($urandom);
            fb_addr   = 6'($urandom);
            fb_data   = 2'($urandom);
            pal_we    = ($urandom_range(0, 7) == 0);
            pal_sel   = 2'($urandom);
            pal_color = 24'($urandom);
            bright    = 2'($urandom);
            pixel     = 6'($urandom);
            page_sel  = 2'($urandom);
            if ($urandom_range(0, 31) == 0) auto_rot = ~auto_rot;
            if ($urandom_range(0, 15) == 0) last_page = 2'($urandom);
            if ($urandom_range(0, 399) == 0) async_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
